// File: rtl/mips32_pkg.sv
// Shared opcodes, instruction classes and decode helpers for the mips32 pipeline.
// The bubble encoding uses an opcode outside the subset so it decodes as NOP.
package mips32_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  localparam logic [5:0]  OP_BUBBLE = 6'b111110;
  localparam logic [31:0] NOP_INSTR = {OP_BUBBLE, 26'd0};

  typedef enum logic [2:0] {
    RR_ALU,
    RM_ALU,
    LOAD,
    STORE,
    BRANCH,
    HALT,
    NOP
  } instr_type_e;

  function automatic instr_type_e decode_type(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: decode_type = RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                     decode_type = RM_ALU;
      OP_LW:                                         decode_type = LOAD;
      OP_SW:                                         decode_type = STORE;
      OP_BNEQZ, OP_BEQZ:                             decode_type = BRANCH;
      OP_HLT:                                        decode_type = HALT;
      default:                                       decode_type = NOP;
    endcase
  endfunction

  function automatic logic uses_rs(input instr_type_e t);
    uses_rs = (t == RR_ALU) || (t == RM_ALU) || (t == LOAD) || (t == STORE) || (t == BRANCH);
  endfunction

  function automatic logic uses_rt(input instr_type_e t);
    uses_rt = (t == RR_ALU) || (t == STORE);
  endfunction

  function automatic logic uses_imm(input instr_type_e t);
    uses_imm = (t == RM_ALU) || (t == LOAD) || (t == STORE);
  endfunction

  function automatic logic is_alu_write(input instr_type_e t);
    is_alu_write = (t == RR_ALU) || (t == RM_ALU);
  endfunction

endpackage

// File: rtl/mips32_if.sv
// Operand/result bus between the pipeline EX stage (master) and the ALU (slave).
interface mips32_if #(
  parameter int XLEN = 32
);
  logic [5:0]      opcode;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [XLEN-1:0] result;
  logic            zero;

  modport master (output opcode, output a, output b, input result, input zero);
  modport slave  (input opcode, input a, input b, output result, output zero);
endinterface

// File: rtl/mips32_alu.sv
// Combinational ALU. Branch opcodes pass operand A through so zero reports A == 0.
module mips32_alu
  import mips32_pkg::*;
(
  mips32_if.slave bus
);

  always_comb begin
    bus.result = '0;
    case (bus.opcode)
      OP_ADD, OP_ADDI, OP_LW, OP_SW: bus.result = bus.a + bus.b;
      OP_SUB, OP_SUBI:               bus.result = bus.a - bus.b;
      OP_AND:                        bus.result = bus.a & bus.b;
      OP_OR:                         bus.result = bus.a | bus.b;
      OP_SLT, OP_SLTI:               bus.result[0] = ($signed(bus.a) < $signed(bus.b));
      OP_MUL:                        bus.result = bus.a * bus.b;
      OP_BNEQZ, OP_BEQZ:             bus.result = bus.a;
      default:                       bus.result = '0;
    endcase
  end

  assign bus.zero = (bus.result == '0);

endmodule

// File: rtl/mips32_pipeline.sv
// Five-stage in-order MIPS32-subset core with forwarding, load-use stall,
// branch squash and a unified word-addressed memory.
module mips32_pipeline
  import mips32_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int XLEN      = 32
) (
  input  logic        clk1,
  input  logic        rst,
  output logic        halted,
  output logic [31:0] pc
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [XLEN-1:0] Reg [0:31];
  logic [XLEN-1:0] mem [0:MEM_WORDS-1];
  logic [31:0]     PC;
  logic            HALTED;
  logic            TAKEN_BRANCH;
  logic            r_fetch_stop;

  logic [31:0]     r_ifid_ir, r_ifid_npc;

  instr_type_e     r_idex_type;
  logic [5:0]      r_idex_op;
  logic [4:0]      r_idex_rs, r_idex_rt, r_idex_dest;
  logic [XLEN-1:0] r_idex_a, r_idex_b, r_idex_imm;
  logic [31:0]     r_idex_npc;

  instr_type_e     r_exmem_type;
  logic [4:0]      r_exmem_dest;
  logic [XLEN-1:0] r_exmem_alu, r_exmem_b;

  instr_type_e     r_memwb_type;
  logic [4:0]      r_memwb_dest;
  logic [XLEN-1:0] r_memwb_alu, r_memwb_lmd;

  logic [31:0]     w_if_ir;
  logic [5:0]      w_id_op;
  instr_type_e     w_id_type;
  logic [4:0]      w_id_rs, w_id_rt, w_id_rd, w_id_dest;
  logic [XLEN-1:0] w_id_imm, w_id_a, w_id_b;
  logic            w_id_hlt, w_load_use;
  logic            w_wb_en, w_fwd_em;
  logic [XLEN-1:0] w_wb_data, w_ex_a, w_ex_b, w_lmd;
  logic            w_taken;
  logic [31:0]     w_target;
  logic [AW-1:0]   w_mem_addr;

  mips32_if #(.XLEN(XLEN)) w_alu_bus ();
  mips32_alu u_alu (.bus(w_alu_bus.slave));

  assign w_if_ir = mem[PC[AW-1:0]];

  assign w_id_op   = r_ifid_ir[31:26];
  assign w_id_type = decode_type(w_id_op);
  assign w_id_rs   = r_ifid_ir[25:21];
  assign w_id_rt   = r_ifid_ir[20:16];
  assign w_id_rd   = r_ifid_ir[15:11];
  assign w_id_imm  = {{(XLEN-16){r_ifid_ir[15]}}, r_ifid_ir[15:0]};
  assign w_id_dest = (w_id_type == RR_ALU) ? w_id_rd :
                     ((w_id_type == RM_ALU) || (w_id_type == LOAD)) ? w_id_rt : 5'd0;

  assign w_wb_en   = (is_alu_write(r_memwb_type) || (r_memwb_type == LOAD)) && (r_memwb_dest != 5'd0);
  assign w_wb_data = (r_memwb_type == LOAD) ? r_memwb_lmd : r_memwb_alu;

  // Register reads see a same-cycle WB write; R0 always reads as zero.
  assign w_id_a = (w_id_rs == 5'd0) ? '0 :
                  (w_wb_en && (r_memwb_dest == w_id_rs)) ? w_wb_data : Reg[w_id_rs];
  assign w_id_b = (w_id_rt == 5'd0) ? '0 :
                  (w_wb_en && (r_memwb_dest == w_id_rt)) ? w_wb_data : Reg[w_id_rt];

  assign w_id_hlt   = (w_id_type == HALT);
  assign w_load_use = (r_idex_type == LOAD) && (r_idex_dest != 5'd0) &&
                      ((uses_rs(w_id_type) && (w_id_rs == r_idex_dest)) ||
                       (uses_rt(w_id_type) && (w_id_rt == r_idex_dest)));

  // EX/MEM forwarding only carries ALU results; a load there is covered by the stall.
  assign w_fwd_em = is_alu_write(r_exmem_type) && (r_exmem_dest != 5'd0);
  assign w_ex_a = (w_fwd_em && (r_exmem_dest == r_idex_rs)) ? r_exmem_alu :
                  (w_wb_en && (r_memwb_dest == r_idex_rs)) ? w_wb_data : r_idex_a;
  assign w_ex_b = (w_fwd_em && (r_exmem_dest == r_idex_rt)) ? r_exmem_alu :
                  (w_wb_en && (r_memwb_dest == r_idex_rt)) ? w_wb_data : r_idex_b;

  assign w_alu_bus.opcode = r_idex_op;
  assign w_alu_bus.a      = w_ex_a;
  assign w_alu_bus.b      = uses_imm(r_idex_type) ? r_idex_imm : w_ex_b;

  assign w_taken  = (r_idex_type == BRANCH) &&
                    ((r_idex_op == OP_BEQZ) ? w_alu_bus.zero : !w_alu_bus.zero);
  assign w_target = r_idex_npc + r_idex_imm[31:0];

  assign w_mem_addr = r_exmem_alu[AW-1:0];
  assign w_lmd      = mem[w_mem_addr];

  always_ff @(posedge clk1) begin
    if (rst) begin
      PC           <= 32'd0;
      HALTED       <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
      r_fetch_stop <= 1'b0;
      r_ifid_ir    <= NOP_INSTR;
      r_ifid_npc   <= 32'd0;
      r_idex_type  <= NOP;
      r_exmem_type <= NOP;
      r_memwb_type <= NOP;
    end else if (!HALTED) begin
      TAKEN_BRANCH <= w_taken;
      r_fetch_stop <= r_fetch_stop || (w_id_hlt && !w_taken);

      // Squash beats stall beats halt; a stall holds PC and IF/ID untouched.
      if (w_taken) begin
        PC        <= w_target;
        r_ifid_ir <= NOP_INSTR;
      end else if (w_load_use) begin
        PC        <= PC;
      end else if (r_fetch_stop || w_id_hlt) begin
        r_ifid_ir <= NOP_INSTR;
      end else begin
        PC         <= PC + 32'd1;
        r_ifid_ir  <= w_if_ir;
        r_ifid_npc <= PC + 32'd1;
      end

      r_idex_type <= (w_taken || w_load_use) ? NOP : w_id_type;
      r_idex_op   <= w_id_op;
      r_idex_rs   <= w_id_rs;
      r_idex_rt   <= w_id_rt;
      r_idex_dest <= w_id_dest;
      r_idex_a    <= w_id_a;
      r_idex_b    <= w_id_b;
      r_idex_imm  <= w_id_imm;
      r_idex_npc  <= r_ifid_npc;

      r_exmem_type <= r_idex_type;
      r_exmem_dest <= r_idex_dest;
      r_exmem_alu  <= w_alu_bus.result;
      r_exmem_b    <= w_ex_b;

      r_memwb_type <= r_exmem_type;
      r_memwb_dest <= r_exmem_dest;
      r_memwb_alu  <= r_exmem_alu;
      r_memwb_lmd  <= w_lmd;

      HALTED <= (r_memwb_type == HALT);
    end
  end

  // Register file and memory are deliberately left uninitialised by reset.
  always_ff @(posedge clk1) begin
    if (!rst && !HALTED && w_wb_en)
      Reg[r_memwb_dest] <= w_wb_data;
  end

  always_ff @(posedge clk1) begin
    if (!rst && !HALTED && (r_exmem_type == STORE))
      mem[w_mem_addr] <= r_exmem_b;
  end

  assign halted = HALTED;
  assign pc     = PC;

endmodule

// File: tb/tb_mips32_pipeline.sv
// Directed programs for mips32_pipeline with hand-computed results, plus a
// few standalone ALU vectors through the operand bus interface.
module tb_mips32_pipeline;
  import mips32_pkg::*;

  typedef logic [31:0] word_q_t[$];

  logic        clk1 = 1'b0;
  logic        rst  = 1'b1;
  logic        halted;
  logic [31:0] pc;

  int checks   = 0;
  int failures = 0;
  int taken_cnt;
  int run_cycles;
  int reg2_seq[$];

  mips32_pipeline #(.MEM_WORDS(1024), .XLEN(32)) dut (
    .clk1   (clk1),
    .rst    (rst),
    .halted (halted),
    .pc     (pc)
  );

  mips32_if #(.XLEN(32)) alu_bus ();
  mips32_alu u_alu (.bus(alu_bus));

  always #5 clk1 = ~clk1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d (0x%08h) expected=%0d (0x%08h)", tag, got, got, exp, exp);
    end else begin
      $display("ok   %s value=%0d", tag, got);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Load happens with rst held so the core cannot write while the bench does.
  task automatic load_program(input word_q_t prog);
    @(negedge clk1);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) dut.Reg[i] = i;
    for (int i = 0; i < 64; i++) dut.mem[i] = 32'd0;
    for (int i = 0; i < prog.size(); i++) dut.mem[i] = prog[i];
    dut.mem[198] = 32'd0;
    dut.mem[200] = 32'd7;
    repeat (2) @(negedge clk1);
    rst = 1'b0;
  endtask

  task automatic run_until_halt(input int max_cycles);
    int prev;
    prev       = dut.Reg[2];
    taken_cnt  = 0;
    run_cycles = 0;
    reg2_seq.delete();
    while (!halted && run_cycles < max_cycles) begin
      @(negedge clk1);
      run_cycles++;
      if (dut.TAKEN_BRANCH) taken_cnt++;
      if (int'(dut.Reg[2]) != prev) begin
        prev = dut.Reg[2];
        reg2_seq.push_back(prev);
      end
    end
  endtask

  initial begin
    word_q_t fact_pad, fact_tight, arith, brprog, r0prog;
    int exp_seq[7] = '{1, 7, 42, 210, 840, 2520, 5040};
    logic [31:0] pc_at_halt;

    fact_pad   = '{32'h280a00c8, 32'h28020001, 32'h0e94a000, 32'h21430000, 32'h0e94a000,
                   32'h14431000, 32'h2c630001, 32'h0e94a000, 32'h3460fffc, 32'h2542fffe,
                   32'hfc000000};
    fact_tight = '{32'h280a00c8, 32'h28020001, 32'h21430000, 32'h14431000, 32'h2c630001,
                   32'h3460fffd, 32'h2542fffe, 32'hfc000000};
    arith  = '{enc_i(6'b001010, 0, 1, 16'd10), enc_i(6'b001010, 0, 2, 16'd20),
               enc_r(6'b000000, 1, 2, 3), enc_r(6'b000001, 3, 1, 4),
               enc_r(6'b000100, 1, 2, 5), enc_r(6'b000101, 3, 4, 6), 32'hfc000000};
    brprog = '{enc_i(6'b001101, 0, 0, 16'd10), enc_i(6'b001110, 0, 0, 16'd2),
               enc_i(6'b001010, 0, 7, 16'd99), enc_i(6'b001010, 7, 7, 16'd1),
               enc_i(6'b001010, 0, 9, 16'd5), 32'hfc000000};
    r0prog = '{enc_i(6'b001010, 0, 0, 16'd5), enc_r(6'b000000, 0, 0, 8), 32'hfc000000};

    // Factorial with padding; also covers the reset state.
    load_program(fact_pad);
    check("reset_pc", pc, 32'd0);
    check("reset_halted", {31'd0, halted}, 32'd0);
    check("reset_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);
    run_until_halt(100);
    check("fact_halted", {31'd0, halted}, 32'd1);
    check("fact_seq_len", reg2_seq.size(), 32'd7);
    for (int i = 0; i < 7 && i < reg2_seq.size(); i++)
      check($sformatf("fact_r2_step%0d", i), reg2_seq[i], exp_seq[i]);
    check("fact_mem198", dut.mem[198], 32'd5040);
    check("fact_mem200", dut.mem[200], 32'd7);
    pc_at_halt = pc;
    repeat (5) @(negedge clk1);
    check("halt_pc_frozen", pc, pc_at_halt);

    // Same program without padding relies on forwarding and the load-use stall.
    load_program(fact_tight);
    run_until_halt(100);
    check("tight_halted", {31'd0, halted}, 32'd1);
    check("tight_seq_len", reg2_seq.size(), 32'd7);
    check("tight_r2", dut.Reg[2], 32'd5040);
    check("tight_mem198", dut.mem[198], 32'd5040);
    check("tight_mem200", dut.mem[200], 32'd7);

    load_program(arith);
    run_until_halt(60);
    check("arith_halted", {31'd0, halted}, 32'd1);
    check("arith_r1", dut.Reg[1], 32'd10);
    check("arith_r2", dut.Reg[2], 32'd20);
    check("arith_r3", dut.Reg[3], 32'd30);
    check("arith_r4", dut.Reg[4], 32'd20);
    check("arith_r5", dut.Reg[5], 32'd1);
    check("arith_r6", dut.Reg[6], 32'd600);

    load_program(brprog);
    run_until_halt(60);
    check("br_halted", {31'd0, halted}, 32'd1);
    check("br_r7_kept", dut.Reg[7], 32'd7);
    check("br_r9", dut.Reg[9], 32'd5);
    check("br_taken_pulses", taken_cnt, 32'd1);

    load_program(r0prog);
    run_until_halt(60);
    check("r0_halted", {31'd0, halted}, 32'd1);
    check("r0_r8", dut.Reg[8], 32'd0);
    check("r0_reg0", dut.Reg[0], 32'd0);

    // Reset in the middle of the factorial loop, then let it rerun.
    load_program(fact_pad);
    repeat (25) @(negedge clk1);
    check("mid_not_halted", {31'd0, halted}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk1);
    check("mid_rst_pc", pc, 32'd0);
    check("mid_rst_halted", {31'd0, halted}, 32'd0);
    check("mid_rst_idex_bubble", {29'd0, dut.r_idex_type}, {29'd0, NOP});
    check("mid_rst_memwb_bubble", {29'd0, dut.r_memwb_type}, {29'd0, NOP});
    check("mid_rst_r10_kept", dut.Reg[10], 32'd200);
    check("mid_rst_mem200_kept", dut.mem[200], 32'd7);
    rst = 1'b0;
    run_until_halt(100);
    check("mid_rerun_halted", {31'd0, halted}, 32'd1);
    check("mid_rerun_r2", dut.Reg[2], 32'd5040);
    check("mid_rerun_mem198", dut.mem[198], 32'd5040);

    // Standalone ALU vectors.
    alu_bus.opcode = 6'b000100; alu_bus.a = 32'hffffffff; alu_bus.b = 32'd1;
    #1 check("alu_slt_signed", alu_bus.result, 32'd1);
    alu_bus.opcode = 6'b000101; alu_bus.a = 32'h00010001; alu_bus.b = 32'h00010000;
    #1 check("alu_mul_low", alu_bus.result, 32'h00010000);
    alu_bus.opcode = 6'b000001; alu_bus.a = 32'd9; alu_bus.b = 32'd9;
    #1 check("alu_sub_zero", {31'd0, alu_bus.zero}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips32_pipeline.md
Name: mips32_pipeline

Overview:
- Five-stage (IF, ID, EX, MEM, WB) in-order pipelined processor for a reduced MIPS32 integer subset, with a unified word-addressed instruction/data memory held inside the block.
- Used as the top-level CPU core in simulation. Program and data are preloaded hierarchically into memory and registers, and the core runs until it retires HLT.
- Hazards are resolved in hardware (forwarding, load-use stall, branch squash), so software NOP padding is optional.

Parameters:
- MEM_WORDS, 1024, depth of unified 32-bit memory; address = low log2(MEM_WORDS) bits of the word address.
- XLEN, 32, datapath/register width.

Ports:
- clk1  input  1  single system clock, rising-edge; all state updates on this edge.
- rst  input  1  synchronous, active-high reset.
- halted  output  1  mirror of internal HALTED.
- pc  output  32  mirror of internal PC (fetch address).

Behaviour:
- Hierarchically accessible state, names fixed:
  - Reg[0:31] (32x32 register file)
  - mem[0:MEM_WORDS-1] (32-bit words)
  - PC
  - HALTED
  - TAKEN_BRANCH
- Reset (rst=1 at posedge):
  - PC=0, HALTED=0, TAKEN_BRANCH=0.
  - All pipeline registers become bubbles (no writes).
  - Reg and mem are NOT cleared.
  - halted=0 and pc=0 the cycle after reset.
- Encoding: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0] sign-extended to 32 bits.
- R-type ops (Reg[rd] = Reg[rs] op Reg[rt]), opcode values:
  - ADD 000000, SUB 000001, AND 000010, OR 000011
  - SLT 000100 (signed, result 1/0)
  - MUL 000101 (low 32 bits of product)
- I-type ops, opcode values:
  - LW 001000: Reg[rt] = mem[Reg[rs]+imm]
  - SW 001001: mem[Reg[rs]+imm] = Reg[rt]
  - ADDI 001010, SUBI 001011, SLTI 001100: Reg[rt] = Reg[rs] op imm
  - BNEQZ 001101: taken if Reg[rs]!=0
  - BEQZ 001110: taken if Reg[rs]==0
  - HLT 111111
- Any other opcode executes as a NOP.
- Branch target = (branch address + 1) + imm, in word units. Example: BNEQZ at 8 with imm -4 targets 5.
- Register R0:
  - Reads as 0.
  - Writes to R0 are discarded.
- Register file is write-before-read: a WB write in a cycle is visible to an ID read in the same cycle.
- Forwarding into EX operands, including the branch condition and SW store data:
  - Priority 1: EX/MEM ALU result.
  - Priority 2: MEM/WB result (ALU result or load data).
- Load-use hazard: an instruction in ID that needs the rt of an LW currently in EX stalls one cycle. During the stall, PC and IF/ID hold and a bubble is inserted into EX.
- Branches resolve in EX; there are no delay slots.
  - Taken: PC loads the target next cycle; the two younger instructions (IF/ID, ID/EX) are squashed to bubbles.
  - TAKEN_BRANCH pulses 1 for that cycle.
  - Not taken: no penalty.
- Halt sequence:
  - HLT decoded in ID stops fetching; PC freezes and the younger fetched instruction is squashed.
  - Older instructions drain.
  - HLT sets HALTED=1 when it reaches WB.
  - Once HALTED=1, no further state changes until rst.
- Memory reads are combinational within MEM. Memory writes occur at the clock edge in MEM.
- Instruction fetch reads mem[PC] combinationally.

Decomposition:
- Package mips32_pkg: opcode localparams, instruction-type enum (RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP), and the bubble/NOP encoding.
- One sub-module: mips32_alu, combinational. Inputs: opcode, operand A, operand B. Outputs: 32-bit result and zero flag.
- Forwarding, hazard control, register file and memory stay in the top level.

Test Plan:
- Factorial program, preloaded via Reg[k]=k and mem[200]=7, with rst for 2 cycles:
  - Program: mem[0..10] = 280a00c8, 28020001, 0e94a000, 21430000, 0e94a000, 14431000, 2c630001, 0e94a000, 3460fffc, 2542fffe, fc000000.
  - Required: Reg[2] takes 1,7,42,210,840,2520,5040; mem[198]=5040; mem[200]=7; halted=1 within 100 cycles.
- Same program with all 0e94a000 padding removed (branch offset adjusted to -3) -> identical results, proving forwarding and the load-use stall.
- Arithmetic with back-to-back dependencies:
  - Program: ADDI R1,R0,10; ADDI R2,R0,20; ADD R3,R1,R2; SUB R4,R3,R1; SLT R5,R1,R2; MUL R6,R3,R4; HLT.
  - Required: R3=30, R4=20, R5=1, R6=600.
- BEQZ taken over two instructions that write R7 -> R7 unchanged (squash works); TAKEN_BRANCH pulses exactly once.
- Write to R0 (ADDI R0,R0,5), then ADD R8,R0,R0 -> R8=0.
- Assert rst mid-run while not halted -> PC=0, halted=0, pipeline empty; Reg/mem contents retained; program reruns correctly.
